// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : inst_mem_loader_if                                         |
// | Brief    : Host byte-stream link plus instruction-memory write port,  |
// |            as seen by the program loader.                             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface inst_mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Loader side: consumes bytes, drives the memory write port.
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  // Host / memory side.
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : inst_mem_loader                                            |
// | Brief    : Receives a length-prefixed big-endian program image over a |
// |            byte link, writes it into instruction memory and holds the |
// |            CPU in reset until the load is complete.                   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module inst_mem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire                clk,
  input  wire                rst_n,
  input  wire                start,
  inst_mem_loader_if.master  bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CNT_HI   = 3'd1,
    S_CNT_LO   = 3'd2,
    S_ASSEMBLE = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Largest value words_loaded may reach (memory depth).
  localparam logic [ADDR_W:0] c_wl_max = {1'b1, {ADDR_W{1'b0}}};

  state_t      r_state;
  logic [15:0] r_count;     // word count N from the frame header
  logic [15:0] r_index;     // index of the word currently being received
  logic [1:0]  r_byte_idx;  // byte position within the current word
  logic [31:0] r_asm;       // word assembly shift register

  logic w_accept;
  logic w_in_range;
  logic w_last;

  assign w_accept   = bus.rx_valid & bus.rx_ready;
  // Word index fits in memory when no bit at or above ADDR_W is set.
  assign w_in_range = ((r_index >> ADDR_W) == 16'd0);
  assign w_last     = ((r_index + 16'd1) == r_count);

  // Frame parser and write sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= 16'd0;
      r_index       <= 16'd0;
      r_byte_idx    <= 2'd0;
      r_asm         <= 32'd0;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= 32'd0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      words_loaded  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_CNT_HI;
            r_byte_idx   <= 2'd0;
            bus.rx_ready <= 1'b1;
            bus.mem_addr <= BASE_ADDR;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
          end
        end

        S_CNT_HI: begin
          if (w_accept) begin
            r_count[15:8] <= bus.rx_data;
            r_state       <= S_CNT_LO;
          end
        end

        S_CNT_LO: begin
          if (w_accept) begin
            r_count[7:0] <= bus.rx_data;
            if ({r_count[15:8], bus.rx_data} == 16'd0) begin
              // Empty image: nothing to write, release the CPU at once.
              r_state      <= S_DONE;
              bus.rx_ready <= 1'b0;
              cpu_hold     <= 1'b0;
              done         <= 1'b1;
            end else begin
              r_state    <= S_ASSEMBLE;
              r_byte_idx <= 2'd0;
              r_index    <= 16'd0;
            end
          end
        end

        S_ASSEMBLE: begin
          if (w_accept) begin
            r_asm      <= {r_asm[23:0], bus.rx_data};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Present the completed word during the single WRITE cycle.
              r_state       <= S_WRITE;
              bus.rx_ready  <= 1'b0;
              bus.mem_wdata <= {r_asm[23:0], bus.rx_data};
              if (w_in_range) begin
                bus.mem_we <= 1'b1;
                if (words_loaded != c_wl_max) begin
                  words_loaded <= words_loaded + 1'b1;
                end
              end else begin
                // Image exceeds memory: drop the word, flag the overflow.
                err <= 1'b1;
              end
            end
          end
        end

        S_WRITE: begin
          bus.mem_we <= 1'b0;
          if (w_last) begin
            r_state  <= S_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_state      <= S_ASSEMBLE;
            r_index      <= r_index + 16'd1;
            r_byte_idx   <= 2'd0;
            bus.mem_addr <= bus.mem_addr + 32'd4;
            bus.rx_ready <= 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          bus.rx_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_inst_mem_loader                                         |
// | Brief    : Scoreboard bench; two loaders (small memory at base 0 and  |
// |            larger memory at base 0x100) share one byte stream.        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_inst_mem_loader;
  localparam int          AW_A   = 2;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam int          AW_B   = 8;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_valid = 1'b0;

  logic cpu_hold_a, done_a, err_a;
  logic [AW_A:0] wl_a;
  logic cpu_hold_b, done_b, err_b;
  logic [AW_B:0] wl_b;

  inst_mem_loader_if ifa ();
  inst_mem_loader_if ifb ();

  assign ifa.rx_data  = rx_data;
  assign ifa.rx_valid = rx_valid;
  assign ifb.rx_data  = rx_data;
  assign ifb.rx_valid = rx_valid;

  inst_mem_loader #(.ADDR_W(AW_A), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifa.master),
    .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a), .words_loaded(wl_a)
  );

  inst_mem_loader #(.ADDR_W(AW_B), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifb.master),
    .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b), .words_loaded(wl_b)
  );

  always #5 clk = ~clk;

  wr_t q_a[$];
  wr_t q_b[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for loader A: every write strobe must match the next expected write.
  always @(negedge clk) begin : mon_a
    wr_t e;
    if (rst_n && ifa.mem_we) begin
      check("a_ready_low_in_write", {31'd0, ifa.rx_ready}, 32'd0);
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_write: addr %h data %h expected no write", ifa.mem_addr, ifa.mem_wdata);
      end else begin
        e = q_a.pop_front();
        check("a_addr", ifa.mem_addr, e.addr);
        check("a_data", ifa.mem_wdata, e.data);
      end
    end
  end

  // Monitor for loader B.
  always @(negedge clk) begin : mon_b
    wr_t e;
    if (rst_n && ifb.mem_we) begin
      check("b_ready_low_in_write", {31'd0, ifb.rx_ready}, 32'd0);
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_write: addr %h data %h expected no write", ifb.mem_addr, ifb.mem_wdata);
      end else begin
        e = q_b.pop_front();
        check("b_addr", ifb.mem_addr, e.addr);
        check("b_data", ifb.mem_wdata, e.data);
      end
    end
  end

  // Offer one byte; returns on the falling edge after it was accepted.
  // gap_mode: 0 = no idle cycle, 1 = one idle cycle, 2 = random 0..2.
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gaps;
    int waitc;
    gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
    for (int g = 0; g < gaps; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waitc    = 0;
    while (!ifa.rx_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    if (!ifa.rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: byte %h not accepted within 40 cycles", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load one frame; expected writes come from the image layout, not the DUT.
  task automatic run_frame(input word_q_t w, input int gap_mode, input bit poke);
    int n;
    int cap_a;
    int cap_b;
    int waitc;
    logic [15:0] nn;
    logic [31:0] wd;
    n     = w.size();
    nn    = n[15:0];
    cap_a = 1 << AW_A;
    cap_b = 1 << AW_B;
    for (int i = 0; i < n; i++) begin
      if (i < cap_a) q_a.push_back('{addr: BASE_A + 32'(4 * i), data: w[i]});
      if (i < cap_b) q_b.push_back('{addr: BASE_B + 32'(4 * i), data: w[i]});
    end
    pulse_start();
    check("a_hold_after_start", {31'd0, cpu_hold_a}, 32'd1);
    check("b_done_after_start", {31'd0, done_b}, 32'd0);
    check("a_err_cleared", {31'd0, err_a}, 32'd0);
    check("b_wl_cleared", 32'(wl_b), 32'd0);
    send_byte(nn[15:8], gap_mode);
    send_byte(nn[7:0], gap_mode);
    if (n == 0) begin
      check("empty_done_a", {31'd0, done_a}, 32'd1);
      check("empty_hold_b", {31'd0, cpu_hold_b}, 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      wd = w[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(wd[31 - 8 * b -: 8], gap_mode);
        if (poke && i == 0 && b == 0) pulse_start();
      end
      check("write_latency_a", {31'd0, ifa.mem_we}, (i < cap_a) ? 32'd1 : 32'd0);
      check("write_latency_b", {31'd0, ifb.mem_we}, 32'd1);
    end
    waitc = 0;
    while (!(done_a && done_b) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("a_done", {31'd0, done_a}, 32'd1);
    check("a_cpu_hold", {31'd0, cpu_hold_a}, 32'd0);
    check("a_err", {31'd0, err_a}, (n > cap_a) ? 32'd1 : 32'd0);
    check("a_words_loaded", 32'(wl_a), 32'((n < cap_a) ? n : cap_a));
    check("b_done", {31'd0, done_b}, 32'd1);
    check("b_cpu_hold", {31'd0, cpu_hold_b}, 32'd0);
    check("b_err", {31'd0, err_b}, (n > cap_b) ? 32'd1 : 32'd0);
    check("b_words_loaded", 32'(wl_b), 32'((n < cap_b) ? n : cap_b));
    check("a_writes_outstanding", 32'(q_a.size()), 32'd0);
    check("b_writes_outstanding", 32'(q_b.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_a_ready", {31'd0, ifa.rx_ready}, 32'd0);
    check("rst_a_we", {31'd0, ifa.mem_we}, 32'd0);
    check("rst_a_addr", ifa.mem_addr, BASE_A);
    check("rst_a_wdata", ifa.mem_wdata, 32'd0);
    check("rst_a_hold", {31'd0, cpu_hold_a}, 32'd1);
    check("rst_a_done", {31'd0, done_a}, 32'd0);
    check("rst_a_err", {31'd0, err_a}, 32'd0);
    check("rst_a_wl", 32'(wl_a), 32'd0);
    check("rst_b_ready", {31'd0, ifb.rx_ready}, 32'd0);
    check("rst_b_we", {31'd0, ifb.mem_we}, 32'd0);
    check("rst_b_addr", ifb.mem_addr, BASE_B);
    check("rst_b_wdata", ifb.mem_wdata, 32'd0);
    check("rst_b_hold", {31'd0, cpu_hold_b}, 32'd1);
    check("rst_b_done", {31'd0, done_b}, 32'd0);
    check("rst_b_err", {31'd0, err_b}, 32'd0);
    check("rst_b_wl", 32'(wl_b), 32'd0);
  endtask

  word_q_t img;

  initial begin : stim
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load, then the same image under back-pressure.
    img = {32'h2008_0005, 32'h0109_5020};
    run_frame(img, 0, 1'b0);
    run_frame(img, 1, 1'b0);

    // Empty image.
    img = {};
    run_frame(img, 0, 1'b0);

    // Overflow of the four-word memory.
    img = {};
    for (int i = 0; i < 5; i++) img.push_back($urandom);
    run_frame(img, 0, 1'b0);

    // Reset after two of four data bytes.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    check("rst_hold_a_we", {31'd0, ifa.mem_we}, 32'd0);
    check("rst_hold_b_we", {31'd0, ifb.mem_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    img = {};
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    run_frame(img, 2, 1'b0);

    // Start pulsed mid-word is ignored, then a single-word reload.
    img = {};
    for (int i = 0; i < 2; i++) img.push_back($urandom);
    run_frame(img, 0, 1'b1);
    img = {32'hDEAD_BEEF};
    run_frame(img, 0, 1'b0);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      img = {};
      for (int i = 0; i < int'($urandom_range(7, 0)); i++) img.push_back($urandom);
      run_frame(img, int'($urandom_range(2, 0)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writes a program into the CPU's instruction memory from a byte-stream host link, replacing file preload for hardware bring-up.
- Sits between the host link and the instruction-memory write port. The datapath only reads instruction memory; this block is the writer.
- Holds the CPU in reset until loading completes, then releases it.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; depth = 2^ADDR_W words.
- BASE_ADDR, 32'h00000000, byte address of the first loaded instruction.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  32  byte address of the write (word aligned).
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  1 = CPU held in reset.
- done  output  1  load finished.
- err  output  1  overflow: image larger than memory.
- words_loaded  output  ADDR_W+1  count of words actually written.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE.
  - rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, done=0, err=0, words_loaded=0.
- Byte transfer: a byte is accepted on a rising edge when rx_valid=1 and rx_ready=1. rx_data is sampled only on accepted edges.
- Frame format:
  - 2-byte big-endian word count N.
  - Then N words of 4 bytes each, big-endian (first byte goes to bits [31:24]).
- States:
  - IDLE: rx_ready=0, cpu_hold=1. On start go to CNT_HI, clear err and words_loaded, set mem_addr=BASE_ADDR.
  - CNT_HI: rx_ready=1. On accept, latch N[15:8] and go to CNT_LO.
  - CNT_LO: rx_ready=1. On accept, latch N[7:0]. If N==0 go to DONE, otherwise go to ASSEMBLE with the byte index cleared.
  - ASSEMBLE: rx_ready=1. Each accepted byte shifts into a 32-bit assembly register. On the 4th accepted byte go to WRITE.
  - WRITE:
    - Lasts exactly one cycle, with rx_ready=0.
    - mem_wdata is the assembled word and mem_addr is BASE_ADDR + 4*index.
    - If index < 2^ADDR_W: mem_we=1 and words_loaded increments.
    - Otherwise: mem_we=0 and err=1. The word is consumed and discarded.
    - Next: if words received == N go to DONE. Otherwise advance mem_addr by 4 on the following edge and go to ASSEMBLE.
  - DONE: rx_ready=0, cpu_hold=0, done=1. start returns to CNT_HI, which re-asserts cpu_hold and clears done, err and words_loaded.
- Timing:
  - Latency from the 4th accepted byte of a word to mem_we is 1 cycle.
  - Peak throughput is one word per 5 cycles.
- start is ignored in CNT_HI, CNT_LO, ASSEMBLE and WRITE.
- mem_we is never asserted outside WRITE.
- mem_addr bits [1:0] always equal BASE_ADDR[1:0]. mem_addr wraps modulo 2^32.
- err is sticky until the next accepted start or reset.
- Reset asserted mid-load aborts immediately to reset values. No partial write occurs after rst_n falls. Memory contents already written are kept.
- rx_valid held high while rx_ready=0 is not consumed; the byte waits.
- words_loaded saturates at 2^ADDR_W.

Test Plan:
- Basic load: reset, start, send 00 02 | 20 08 00 05 | 01 09 50 20 with rx_valid always high.
  - mem_we pulses twice: addr 0x0 / data 0x20080005, then addr 0x4 / data 0x01095020.
  - done=1, cpu_hold=0, words_loaded=2, err=0.
- Back-pressure: same frame with rx_valid toggling every other cycle, and rx_valid high during the WRITE cycle.
  - Identical writes, no byte lost or duplicated.
  - rx_ready=0 exactly in the WRITE cycle.
- Empty image: send 00 00.
  - DONE two accepts after start, no mem_we, cpu_hold drops.
- Overflow: ADDR_W=2, N=5, five distinct words.
  - Four writes at 0x0 to 0xC, the fifth word is not written.
  - err=1, words_loaded=4, done=1.
- Reset mid-operation: rst_n=0 after 2 of 4 data bytes.
  - All outputs return to reset values asynchronously and no mem_we occurs.
  - A subsequent start and full frame loads correctly.
- Reload and ignored start: start pulsed during ASSEMBLE has no effect. After DONE, start again with BASE_ADDR=0x100 and N=1.
  - cpu_hold re-asserts, single write at 0x100, done returns to 1.
